// File: rtl/panda_data_mem.sv
// panda_data_mem: single-port 32-bit word data memory with per-byte write strobes, serving the core's load/store interface.
// Latency: a request accepted at edge N produces a one-cycle rvalid_o in cycle N+1+WAIT_CYCLES.
// Backpressure: gnt_o is high only while IDLE, so the requester holds req_i and its payload until granted.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge); asynchronous active-low reset
//   req_i, gnt_o         request valid, accepted when req_i & gnt_o
//   addr_i, we_i         byte address (bits [1:0] ignored); byte write enables (0 = load)
//   wdata_i              store data, already lane-replicated
//   rvalid_o             one-cycle response strobe
//   rdata_o, err_o       load data and out-of-range flag, both meaningful only while rvalid_o
module panda_data_mem #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  CNT_INIT  = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         we_q;
  logic [31:0]        wdata_q;
  logic               in_range_q;

  logic [31:0]        mem [MEM_WORDS];

  logic [31:0]        offset;
  logic [IDX_W-1:0]   req_idx;
  logic               req_in_range;
  logic               accept;

  // Selected access for the commit edge: live inputs when the accepting
  // edge is also the commit edge (zero wait states), latched copy otherwise.
  logic               commit;
  logic [IDX_W-1:0]   c_idx;
  logic [3:0]         c_we;
  logic [31:0]        c_wdata;
  logic               c_in_range;

  assign gnt_o  = (state == IDLE);
  assign accept = req_i & gnt_o;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset       = addr_i - BASE_ADDR;
  assign req_idx      = offset[IDX_W+1:2];
  assign req_in_range = (offset < MEM_BYTES);

  always_comb begin
    commit     = 1'b0;
    c_idx      = idx_q;
    c_we       = we_q;
    c_wdata    = wdata_q;
    c_in_range = in_range_q;
    if (state == IDLE) begin
      commit     = accept && (WAIT_CYCLES == 0);
      c_idx      = req_idx;
      c_we       = we_i;
      c_wdata    = wdata_i;
      c_in_range = req_in_range;
    end else if (state == BUSY) begin
      commit = (cnt == 4'd0);
    end
  end

  // Array is deliberately not reset; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (commit && c_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (c_we[k]) mem[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      idx_q      <= '0;
      we_q       <= 4'd0;
      wdata_q    <= 32'd0;
      in_range_q <= 1'b0;
      rvalid_o   <= 1'b0;
      rdata_o    <= 32'd0;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q      <= req_idx;
            we_q       <= we_i;
            wdata_q    <= wdata_i;
            in_range_q <= req_in_range;
            if (WAIT_CYCLES > 0) begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end else begin
              state <= RESP;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          state    <= IDLE;
          rvalid_o <= 1'b0;
          rdata_o  <= 32'd0;
          err_o    <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Response registers load on the edge entering RESP.
      if (commit) begin
        rvalid_o <= 1'b1;
        err_o    <= ~c_in_range;
        rdata_o  <= (c_in_range && (c_we == 4'd0)) ? mem[c_idx] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_panda_data_mem.sv
// tb_panda_data_mem: directed bench for panda_data_mem with three instances (WAIT_CYCLES 0, 1, 3).
// Latency: checks response arrives WAIT_CYCLES+1 sampled cycles after acceptance.
// Backpressure: holds req_i until granted and checks grant spacing under back-to-back requests.
module tb_panda_data_mem;

  logic        clk_i;
  logic        rst_ni;
  logic        req     [3];
  logic [31:0] addr    [3];
  logic [3:0]  we      [3];
  logic [31:0] wdata   [3];
  logic        gnt     [3];
  logic        rvalid  [3];
  logic [31:0] rdata   [3];
  logic        err     [3];

  int checks = 0;
  int passes = 0;

  // index 0: WAIT=0, index 1: WAIT=1, index 2: WAIT=3 with a non-zero base
  panda_data_mem #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

  panda_data_mem #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  panda_data_mem #(.MEM_WORDS(16), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req[2]), .addr_i(addr[2]), .we_i(we[2]),
    .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One access: wait for grant, drop req after acceptance (scrambling payload),
  // then count sampled cycles until rvalid.
  task automatic do_access(input int d, input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat);
    int guard;
    @(negedge clk_i);
    req[d] = 1'b1; addr[d] = a; we[d] = w; wdata[d] = wd;
    guard = 0;
    while (!gnt[d] && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    req[d] = 1'b0; addr[d] = $urandom; we[d] = 4'hF; wdata[d] = $urandom;
    lat = 1;
    while (!rvalid[d] && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    rd = rdata[d];
    er = err[d];
  endtask

  // Four stores with req held high; payload advances after each grant.
  task automatic b2b(input int d, input logic [31:0] base, input int period);
    int last, ngnt, nrv;
    bit upd;
    last = -1; ngnt = 0; nrv = 0; upd = 0;
    @(negedge clk_i);
    req[d] = 1'b1; addr[d] = base; we[d] = 4'hF; wdata[d] = 32'hB0B0_0000;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (upd) begin
        upd = 0;
        if (ngnt == 4) req[d] = 1'b0;
        else begin
          addr[d]  = base + 32'(4 * ngnt);
          wdata[d] = 32'hB0B0_0000 + 32'(ngnt);
        end
      end
      if (rvalid[d]) nrv++;
      if (req[d] && gnt[d]) begin
        if (last >= 0) check($sformatf("b2b%0d gap", d), 32'(cyc - last), 32'(period));
        last = cyc;
        ngnt++;
        upd = 1;
      end
      @(negedge clk_i);
    end
    check($sformatf("b2b%0d grants", d), 32'(ngnt), 32'd4);
    check($sformatf("b2b%0d rvalids", d), 32'(nrv), 32'd4);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; addr[i] = 32'h0; we[i] = 4'h0; wdata[i] = 32'h0;
    end

    // Reset asserted mid-cycle takes effect immediately
    #2 rst_ni = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst gnt%0d", i), 32'(gnt[i]), 32'd1);
      check($sformatf("rst rvalid%0d", i), 32'(rvalid[i]), 32'd0);
      check($sformatf("rst rdata%0d", i), rdata[i], 32'h0);
      check($sformatf("rst err%0d", i), 32'(err[i]), 32'd0);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst held gnt", 32'(gnt[1]), 32'd1);
    check("rst held rvalid", 32'(rvalid[1]), 32'd0);
    rst_ni = 1'b1;

    // WAIT=1 store then load
    do_access(1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
    check("st10 lat", 32'(lat), 32'd2);
    check("st10 err", 32'(er), 32'd0);
    check("st10 rdata", rd, 32'h0);
    do_access(1, 32'h10, 4'h0, 32'h0, rd, er, lat);
    check("ld10 lat", 32'(lat), 32'd2);
    check("ld10 rdata", rd, 32'hDEADBEEF);
    check("ld10 err", 32'(er), 32'd0);

    // Byte lanes
    do_access(1, 32'h20, 4'hF, 32'h11223344, rd, er, lat);
    do_access(1, 32'h20, 4'b0100, 32'hAAAAAAAA, rd, er, lat);
    do_access(1, 32'h20, 4'h0, 32'h0, rd, er, lat);
    check("lane2 rdata", rd, 32'h11AA3344);
    do_access(1, 32'h20, 4'b1100, 32'h55665566, rd, er, lat);
    do_access(1, 32'h20, 4'h0, 32'h0, rd, er, lat);
    check("lane32 rdata", rd, 32'h55663344);

    // Out of range on 1024-word memory at base 0
    do_access(1, 32'h0, 4'hF, 32'h12345678, rd, er, lat);
    do_access(1, 32'h1000, 4'hF, 32'hFFFFFFFF, rd, er, lat);
    check("oor st err", 32'(er), 32'd1);
    check("oor st rdata", rd, 32'h0);
    do_access(1, 32'h1000, 4'h0, 32'h0, rd, er, lat);
    check("oor ld err", 32'(er), 32'd1);
    check("oor ld rdata", rd, 32'h0);
    do_access(1, 32'h0, 4'h0, 32'h0, rd, er, lat);
    check("ld0 rdata", rd, 32'h12345678);
    check("ld0 err", 32'(er), 32'd0);

    // Non-zero base, 16 words: wrap below base and top boundary
    do_access(2, 32'h7FFF_FFFC, 4'h0, 32'h0, rd, er, lat);
    check("below base err", 32'(er), 32'd1);
    check("dut3 lat", 32'(lat), 32'd4);
    do_access(2, 32'h8000_0040, 4'h0, 32'h0, rd, er, lat);
    check("above top err", 32'(er), 32'd1);
    do_access(2, 32'h8000_003C, 4'hF, 32'hC0FFEE00, rd, er, lat);
    do_access(2, 32'h8000_003E, 4'h0, 32'h0, rd, er, lat);
    check("top word rdata", rd, 32'hC0FFEE00);
    check("top word err", 32'(er), 32'd0);

    // WAIT=0 latency
    do_access(0, 32'h80, 4'hF, 32'h0BADCAFE, rd, er, lat);
    check("dut0 lat", 32'(lat), 32'd1);
    do_access(0, 32'h80, 4'h0, 32'h0, rd, er, lat);
    check("dut0 ld", rd, 32'h0BADCAFE);

    // Back-to-back with req held
    b2b(0, 32'h40, 2);
    b2b(2, 32'h8000_0000, 5);
    for (int k = 0; k < 4; k++) begin
      do_access(0, 32'h40 + 32'(4 * k), 4'h0, 32'h0, rd, er, lat);
      check($sformatf("b2b0 word%0d", k), rd, 32'hB0B0_0000 + 32'(k));
      do_access(2, 32'h8000_0000 + 32'(4 * k), 4'h0, 32'h0, rd, er, lat);
      check($sformatf("b2b3 word%0d", k), rd, 32'hB0B0_0000 + 32'(k));
    end

    // Reset during BUSY of a store drops the store
    do_access(2, 32'h8000_0020, 4'hF, 32'h600DF00D, rd, er, lat);
    @(negedge clk_i);
    req[2] = 1'b1; addr[2] = 32'h8000_0020; we[2] = 4'hF; wdata[2] = 32'hBAD0BAD0;
    @(posedge clk_i);
    @(negedge clk_i);
    req[2] = 1'b0;
    check("busy gnt", 32'(gnt[2]), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mid rst gnt", 32'(gnt[2]), 32'd1);
    check("mid rst rvalid", 32'(rvalid[2]), 32'd0);
    repeat (4) @(negedge clk_i);
    check("mid rst held rvalid", 32'(rvalid[2]), 32'd0);
    rst_ni = 1'b1;
    do_access(2, 32'h8000_0020, 4'h0, 32'h0, rd, er, lat);
    check("aborted store", rd, 32'h600DF00D);
    do_access(1, 32'h10, 4'h0, 32'h0, rd, er, lat);
    check("persist rdata", rd, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/panda_data_mem.md
# panda_data_mem

Single-port data memory that serves the core's data interface as the responder: it accepts load/store requests (word address, 4-bit byte write enable, write data) and returns read data with a configurable, fixed wait-state latency. It sits on the memory side of the core's load/store unit and replaces the zero-latency ideal memory used in early bring-up, so the core's request/grant/valid handling is exercised. Byte-lane placement and sign/zero extension stay in the core; this block operates on whole 32-bit words with per-byte write strobes.

## Interface
Parameters:
- MEM_WORDS, 1024: depth in 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_WORDS*4.
- WAIT_CYCLES, 1: extra cycles between acceptance and response; 0..15.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid; held with its payload until granted.
- addr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  4  byte write enables; 4'b0000 = load, any bit set = store.
- wdata_i  in  32  store data, already lane-replicated by the core.
- gnt_o  out  1  request accepted this cycle when req_i & gnt_o.
- rvalid_o  out  1  one-cycle response strobe.
- rdata_o  out  32  load data; valid only while rvalid_o.
- err_o  out  1  access outside memory range; valid only while rvalid_o.

## Operation
- FSM states IDLE, BUSY, RESP; reset state IDLE.
- gnt_o = (state == IDLE), combinational from state only (no path from req_i).
- IDLE: on req_i & gnt_o latch addr, we, wdata; compute index = (addr_i - BASE_ADDR) >> 2 and in_range = (addr_i - BASE_ADDR) < MEM_WORDS*4 (unsigned, 32-bit, wrap below BASE_ADDR counts as out of range). Next state BUSY with counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0, else RESP.
- BUSY: decrement counter; at counter == 0 go to RESP.
- Commit edge (the edge entering RESP): if in_range and store, write lanes where we bit set (lane k = bits 8k+7:8k), other lanes unchanged; if in_range and load, rdata_o <= mem[index]. rvalid_o <= 1, err_o <= ~in_range. Stores and out-of-range accesses set rdata_o <= 0.
- RESP: rvalid_o high exactly this cycle; next state IDLE; rvalid_o, err_o, rdata_o return to 0 on the next edge.
- Out-of-range store: no array write, err_o = 1.
- Memory array is not reset; contents persist across reset.

## Timing
- Reset values: gnt_o = 1 (IDLE), rvalid_o = 0, rdata_o = 32'h0, err_o = 0, counter = 0.
- Request accepted at edge N: rvalid_o high during cycle N+1+WAIT_CYCLES (WAIT_CYCLES=0: response the cycle after acceptance).
- gnt_o low from cycle after acceptance through RESP cycle inclusive; max throughput one access per WAIT_CYCLES+2 cycles.
- req_i held during BUSY/RESP is not accepted; it is granted in the following IDLE cycle.
- Store then load to the same word: load returns the stored bytes (store committed before load accepted).
- Reset asserted mid-access: state to IDLE, outputs to reset values immediately; a store whose commit edge has not occurred is not written.
- Changes of addr_i/we_i/wdata_i after acceptance have no effect.

## Test plan
- Reset: rst_ni low mid-cycle -> gnt_o=1, rvalid_o=0, rdata_o=0, err_o=0 immediately and held.
- WAIT_CYCLES=1: store addr 0x10, we 4'b1111, wdata 0xDEADBEEF at edge N -> rvalid_o at N+2, err_o=0, rdata_o=0; load 0x10 -> rdata_o=0xDEADBEEF at acceptance+2.
- Byte lanes: after word 0x20 = 0x11223344, store we 4'b0100 wdata 0xAAAAAAAA, then load -> 0x11AA3344; store we 4'b1100 wdata 0x55665566 -> load 0x55663344.
- Out of range (MEM_WORDS=1024, BASE 0): store to 0x1000 then load 0x1000 -> both err_o=1, rdata_o=0; load 0x0 unchanged.
- Back-to-back with req_i held high, WAIT_CYCLES=0 and 3: gnt_o pulses every 2 and 5 cycles, one rvalid_o per grant, no lost or duplicated access.
- Reset during BUSY of a store (WAIT_CYCLES=3) -> after reset, load of that word returns prior contents.
